// File: rtl/ram_responder_if.sv
// RAM port bundle between the cache controller (master) and the memory responder (slave).
interface ram_responder_if;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    // Controller side: drives requests, observes the response.
    modport master (
        output ramREN,
        output ramWEN,
        output ramaddr,
        output ramstore,
        input  ramload,
        input  ramstate
    );

    // Responder side: observes requests, drives the response.
    modport slave (
        input  ramREN,
        input  ramWEN,
        input  ramaddr,
        input  ramstore,
        output ramload,
        output ramstate
    );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM responder with a fixed access latency. A request is held by the
// controller; the responder answers BUSY for LAT cycles, then ACCESS for one cycle.
// ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
module ram_responder #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 2
) (
    input logic         CLK,
    input logic         RST,
    ram_responder_if.slave ram
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {StIdle, StWait, StDone, StFault} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            op_q, op_d;      // 1 = write, 0 = read
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     load_q, load_d;
    logic            mem_we;

    logic [31:0]     mem [DEPTH];

    logic            req_any;
    logic            req_both;
    logic            req_bad;
    logic            op_changed;
    logic            abort;
    logic [31:0]     latched_addr;

    // Request qualification; the latched address is rebuilt from the word index since
    // only aligned, in-range addresses are ever accepted.
    always_comb begin
        req_any      = ram.ramREN | ram.ramWEN;
        req_both     = ram.ramREN & ram.ramWEN;
        req_bad      = req_both || (ram.ramaddr[1:0] != 2'b00) || (ram.ramaddr >= LIMIT);
        latched_addr = 32'({idx_q, 2'b00});
        op_changed   = op_q ? (ram.ramREN & ~ram.ramWEN) : (ram.ramWEN & ~ram.ramREN);
        abort        = !req_any || op_changed || (ram.ramaddr != latched_addr);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        data_d  = data_q;
        load_d  = load_q;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    if (req_bad) begin
                        state_d = StFault;
                    end else begin
                        op_d    = ram.ramWEN;
                        idx_d   = ram.ramaddr[AW+1:2];
                        data_d  = ram.ramstore;
                        cnt_d   = 4'(LAT);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (req_both) begin
                    state_d = StFault;
                end else if (cnt_q == 4'd1) begin
                    // Commit on the DONE-entry edge so a following request sees it.
                    state_d = StDone;
                    if (op_q) begin
                        mem_we = 1'b1;
                    end else begin
                        load_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control and latched-request registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= 32'd0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            load_q  <= load_d;
        end
    end

    // Backing store, deliberately unreset; async reset forces StIdle so no write fires.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx_q] <= data_q;
        end
    end

    // ramstate is a pure decode of the FSM state.
    always_comb begin
        ram.ramstate = RAM_FREE;
        unique case (state_q)
            StIdle:  ram.ramstate = RAM_FREE;
            StWait:  ram.ramstate = RAM_BUSY;
            StDone:  ram.ramstate = RAM_ACCESS;
            StFault: ram.ramstate = RAM_ERROR;
            default: ram.ramstate = RAM_FREE;
        endcase
    end

    assign ram.ramload = load_q;
endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: stimulus queues expected ACCESS/ERROR responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ram_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic clk = 1'b0;
    logic rst;

    ram_responder_if bus ();

    ram_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .CLK (clk),
        .RST (rst),
        .ram (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  state;
        logic [31:0] load;
        bit          chk_load;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ACCESS or ERROR cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.ramstate == ACCESS || bus.ramstate == ERROR)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected response: got state %0d expected none", bus.ramstate);
            end else begin
                e = sb.pop_front();
                check({e.name, " state"}, 32'(bus.ramstate), 32'(e.state));
                if (e.chk_load) check({e.name, " load"}, bus.ramload, e.load);
            end
        end
    end

    // Issue one held request in the current cycle; ramstore switches to alt after BUSY1.
    task automatic req(input string name, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] alt, input bit bad,
                       input logic [31:0] exp_load, input bit chk);
        int n;
        bit done;
        bus.ramREN   = ren;
        bus.ramWEN   = wen;
        bus.ramaddr  = addr;
        bus.ramstore = data;
        sb.push_back('{bad ? ERROR : ACCESS, exp_load, chk, name});
        @(posedge clk);
        n    = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
                done = 1'b1;
            end else begin
                check({name, " busy"}, 32'(bus.ramstate), 32'(BUSY));
                bus.ramstore = alt;
            end
        end
        check({name, " latency"}, 32'(n), bad ? 32'd1 : 32'(LAT + 1));
        bus.ramREN = 1'b0;
        bus.ramWEN = 1'b0;
        @(posedge clk);
        #1;
        check({name, " free after"}, 32'(bus.ramstate), 32'(FREE));
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        rst          = 1'b1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 32'(bus.ramstate), 32'(FREE));
        check("reset load", bus.ramload, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic write then read.
        req("wr40", 0, 1, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'd0, 0);
        req("rd40", 1, 0, 32'h40, 32'd0, 32'd0, 0, 32'hDEADBEEF, 1);

        // Back-to-back write/read of word 0, read issued in the FREE cycle.
        req("wr0", 0, 1, 32'h0, 32'h1, 32'h1, 0, 32'd0, 0);
        req("rd0", 1, 0, 32'h0, 32'd0, 32'd0, 0, 32'h1, 1);
        check("load holds", bus.ramload, 32'h1);

        // Last valid word.
        req("wrtop", 0, 1, 32'hFFC, 32'hCAFEF00D, 32'hCAFEF00D, 0, 32'd0, 0);
        req("rdtop", 1, 0, 32'hFFC, 32'd0, 32'd0, 0, 32'hCAFEF00D, 1);
        req("wr84", 0, 1, 32'h84, 32'h12345678, 32'h12345678, 0, 32'd0, 0);

        // Abort by address change in the last BUSY cycle; request to 0x84 then proceeds.
        held        = 32'hCAFEF00D;
        bus.ramREN  = 1'b1;
        bus.ramaddr = 32'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort busy2", 32'(bus.ramstate), 32'(BUSY));
        bus.ramaddr = 32'h84;
        @(posedge clk); #1;
        check("abort free", 32'(bus.ramstate), 32'(FREE));
        check("abort load", bus.ramload, held);
        req("rd84", 1, 0, 32'h84, 32'd0, 32'd0, 0, 32'h12345678, 1);

        // Abort by dropping the write enable: memory unchanged.
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = 32'h84;
        bus.ramstore = 32'h99;
        @(posedge clk); #1;
        bus.ramWEN = 1'b0;
        @(posedge clk); #1;
        check("drop free", 32'(bus.ramstate), 32'(FREE));
        req("rd84b", 1, 0, 32'h84, 32'd0, 32'd0, 0, 32'h12345678, 1);

        // Bad requests: both enables, misaligned, out of range.
        req("both", 1, 1, 32'h40, 32'h55, 32'h55, 1, 32'd0, 0);
        req("misal", 0, 1, 32'h3, 32'h66, 32'h66, 1, 32'd0, 0);
        req("range", 0, 1, 32'h1000, 32'h77, 32'h77, 1, 32'd0, 0);
        req("rd0 after err", 1, 0, 32'h0, 32'd0, 32'd0, 0, 32'h1, 1);
        req("rd40 after err", 1, 0, 32'h40, 32'd0, 32'd0, 0, 32'hDEADBEEF, 1);

        // ramstore changes during BUSY are ignored.
        req("wr10", 0, 1, 32'h10, 32'hA, 32'hB, 0, 32'd0, 0);
        req("rd10", 1, 0, 32'h10, 32'd0, 32'd0, 0, 32'hA, 1);

        // Reset mid-write drops the write and clears ramload.
        req("wr20", 0, 1, 32'h20, 32'h7, 32'h7, 0, 32'd0, 0);
        req("rd20", 1, 0, 32'h20, 32'd0, 32'd0, 0, 32'h7, 1);
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = 32'h20;
        bus.ramstore = 32'h5;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst state", 32'(bus.ramstate), 32'(FREE));
        check("rst load", bus.ramload, 32'd0);
        bus.ramWEN = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        req("rd20 after rst", 1, 0, 32'h20, 32'd0, 32'd0, 0, 32'h7, 1);

        repeat (2) @(posedge clk);
        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
